// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART with 16x oversampling,
// TX/RX FIFOs, build-time frame format and RX error flags.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   tx_data/valid/rdy  write side of the TX FIFO
//   tx_busy            TX frame in progress or TX FIFO non-empty
//   rx_data/perr/ferr  head word of the RX FIFO (zero when empty)
//   rx_valid/ready     RX FIFO non-empty / pop
//   rx_overrun         one-cycle pulse when a word is dropped
//   UART_RXD/UART_TXD  serial line in / out
module uart_core_param #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  input  logic       UART_RXD,
  output logic       UART_TXD
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [7:0] DMASK = 8'((1 << DATA_BITS) - 1);
  localparam logic PODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_t;

  // Baud tick generator
  logic [CW-1:0] tcnt;
  logic          tick;

  assign tick = (tcnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // TX FIFO
  logic [7:0]       tmem [DEPTH];
  logic [FIFO_AW:0] twp, trp;
  logic             tx_full, tx_empty;
  logic             tx_push, tx_pop;
  logic [7:0]       tx_head;

  assign tx_empty = (twp == trp);
  assign tx_full  = (twp[FIFO_AW] != trp[FIFO_AW]) &&
                    (twp[FIFO_AW-1:0] == trp[FIFO_AW-1:0]);
  assign tx_ready = rst_n & ~tx_full;
  assign tx_push  = tx_valid & tx_ready;
  assign tx_head  = tmem[trp[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tmem[twp[FIFO_AW-1:0]] <= tx_data & DMASK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      twp <= '0;
      trp <= '0;
    end else begin
      if (tx_push) twp <= twp + 1'b1;
      if (tx_pop)  trp <= trp + 1'b1;
    end
  end

  // TX FSM
  st_t        tst, tst_n;
  logic [3:0] tph;
  logic [2:0] tbit;
  logic       tsb;
  logic [7:0] tsh;
  logic       tpar;
  logic       tend;

  assign tend = tick && (tph == 4'd15);

  always_comb begin
    tst_n  = tst;
    tx_pop = 1'b0;
    unique case (tst)
      S_IDLE: begin
        if (tick && !tx_empty) begin
          tst_n  = S_START;
          tx_pop = 1'b1;
        end
      end
      S_START: if (tend) tst_n = S_DATA;
      S_DATA: begin
        if (tend && tbit == 3'(DATA_BITS - 1))
          tst_n = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: if (tend) tst_n = S_STOP;
      S_STOP: begin
        if (tend && tsb == 1'(STOP_BITS - 1)) begin
          // Back-to-back frames: no idle gap if more data waits
          if (!tx_empty) begin
            tst_n  = S_START;
            tx_pop = 1'b1;
          end else begin
            tst_n = S_IDLE;
          end
        end
      end
      default: tst_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tst  <= S_IDLE;
      tph  <= '0;
      tbit <= '0;
      tsb  <= 1'b0;
      tsh  <= '0;
      tpar <= 1'b0;
    end else begin
      tst <= tst_n;
      if (tx_pop) begin
        tsh  <= tx_head;
        tpar <= (^tx_head) ^ PODD;
        tph  <= '0;
        tbit <= '0;
        tsb  <= 1'b0;
      end else begin
        if (tick && tst != S_IDLE) tph <= tph + 1'b1;
        if (tend && tst == S_DATA) begin
          tsh  <= tsh >> 1;
          tbit <= tbit + 1'b1;
        end
        if (tend && tst == S_STOP) tsb <= tsb + 1'b1;
      end
    end
  end

  always_comb begin
    UART_TXD = 1'b1;
    unique case (tst)
      S_START: UART_TXD = 1'b0;
      S_DATA:  UART_TXD = tsh[0];
      S_PAR:   UART_TXD = tpar;
      default: UART_TXD = 1'b1;
    endcase
  end

  assign tx_busy = (tst != S_IDLE) | ~tx_empty;

  // RX synchronizer and edge history
  logic rs1, rxs, rxs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1   <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rs1   <= UART_RXD;
      rxs   <= rs1;
      rxs_d <= rxs;
    end
  end

  // RX FSM
  st_t        rst_q, rst_nx;
  logic [3:0] rph;
  logic [2:0] rbit;
  logic [7:0] rsh;
  logic       s7, s8;
  logic       rperr;
  logic       rwait;
  logic       samp, bend, maj;
  logic       rx_push;
  logic [9:0] rx_wd;

  assign samp  = tick && (rph == 4'd9);
  assign bend  = tick && (rph == 4'd15);
  assign maj   = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign rx_wd = {rperr, ~maj, rsh};

  always_comb begin
    rst_nx  = rst_q;
    rx_push = 1'b0;
    unique case (rst_q)
      S_IDLE: begin
        if (!rwait && rxs_d && !rxs) rst_nx = S_START;
      end
      S_START: begin
        if (tick && rph == 4'd8 && rxs) rst_nx = S_IDLE;
        else if (bend)                  rst_nx = S_DATA;
      end
      S_DATA: begin
        if (bend && rbit == 3'(DATA_BITS - 1))
          rst_nx = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: if (bend) rst_nx = S_STOP;
      S_STOP: begin
        // Push mid stop bit so a following start edge is not missed
        if (samp) begin
          rx_push = 1'b1;
          rst_nx  = S_IDLE;
        end
      end
      default: rst_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_q <= S_IDLE;
      rph   <= '0;
      rbit  <= '0;
      rsh   <= '0;
      s7    <= 1'b1;
      s8    <= 1'b1;
      rperr <= 1'b0;
      rwait <= 1'b0;
    end else begin
      rst_q <= rst_nx;
      if (rst_q == S_IDLE) begin
        rph   <= '0;
        rbit  <= '0;
        rsh   <= '0;
        rperr <= 1'b0;
      end else if (tick) begin
        rph <= rph + 1'b1;
      end
      if (tick && rph == 4'd7) s7 <= rxs;
      if (tick && rph == 4'd8) s8 <= rxs;
      if (samp && rst_q == S_DATA) rsh[rbit] <= maj;
      if (bend && rst_q == S_DATA) rbit <= rbit + 1'b1;
      if (samp && rst_q == S_PAR)
        rperr <= maj ^ (^rsh) ^ PODD;
      // A break holds the line low; stay disarmed until it rises
      if (rx_push)                      rwait <= ~maj;
      else if (rst_q == S_IDLE && rxs)  rwait <= 1'b0;
    end
  end

  // RX FIFO
  logic [9:0]       rmem [DEPTH];
  logic [FIFO_AW:0] rwp, rrp;
  logic             rx_full, rx_empty, rx_pop, rx_wr;
  logic [9:0]       rx_head;

  assign rx_empty = (rwp == rrp);
  assign rx_full  = (rwp[FIFO_AW] != rrp[FIFO_AW]) &&
                    (rwp[FIFO_AW-1:0] == rrp[FIFO_AW-1:0]);
  assign rx_valid = ~rx_empty;
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_wr    = rx_push & (~rx_full | rx_pop);
  assign rx_head  = rx_valid ? rmem[rrp[FIFO_AW-1:0]] : 10'd0;
  assign rx_data  = rx_head[7:0];
  assign rx_ferr  = rx_head[8];
  assign rx_perr  = rx_head[9];

  always_ff @(posedge clk) begin
    if (rx_wr) rmem[rwp[FIFO_AW-1:0]] <= rx_wd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rwp        <= '0;
      rrp        <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_wr)  rwp <= rwp + 1'b1;
      if (rx_pop) rrp <= rrp + 1'b1;
      rx_overrun <= rx_push & rx_full & ~rx_pop;
    end
  end

endmodule
